// File: rtl/ysyx_24100006_pkg.sv
// Shared definitions for the ysyx_24100006 core.
// IFU state encoding, reset PC and AXI-Lite widths.
package ysyx_24100006_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    localparam logic [ADDR_W-1:0] RESET_PC_DEF = 32'h8000_0000;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_ADDR     = 3'd1,
        S_DATA     = 3'd2,
        S_HOLD     = 3'd3,
        S_WAIT_NPC = 3'd4
    } ifu_state_e;

endpackage

// File: rtl/ysyx_24100006_ifu.sv
// Instruction-fetch unit: one AXI-Lite read per instruction,
// handed to IDU over valid/ready, next PC supplied by WBU.
module ysyx_24100006_ifu
    import ysyx_24100006_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEF
) (
    input  logic              clk,
    input  logic              reset,
    output logic [ADDR_W-1:0] axi_araddr,
    output logic              axi_arvalid,
    input  logic              axi_arready,
    input  logic [DATA_W-1:0] axi_rdata,
    input  logic              axi_rvalid,
    output logic              axi_rready,
    output logic              axi_awvalid,
    output logic              axi_wvalid,
    output logic              axi_bready,
    output logic [DATA_W-1:0] axi_wdata,
    input  logic [ADDR_W-1:0] npc,
    input  logic              npc_valid,
    output logic [DATA_W-1:0] if_inst,
    output logic [ADDR_W-1:0] if_pc,
    output logic              if_valid,
    input  logic              id_ready
);

    ifu_state_e        state, state_n;
    logic [ADDR_W-1:0] pc, pc_n;
    logic [DATA_W-1:0] inst_reg, inst_n;
    logic              npc_pend, pend_n;
    logic [ADDR_W-1:0] npc_buf, buf_n;
    logic              npc_early;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            pc       <= RESET_PC;
            inst_reg <= '0;
            npc_pend <= 1'b0;
            npc_buf  <= '0;
        end else begin
            state    <= state_n;
            pc       <= pc_n;
            inst_reg <= inst_n;
            npc_pend <= pend_n;
            npc_buf  <= buf_n;
        end
    end

    // A next PC arriving before WAIT_NPC is parked; ADDR drops it.
    assign npc_early = npc_valid &&
                       (state == S_IDLE ||
                        state == S_DATA ||
                        state == S_HOLD);

    always_comb begin
        state_n = state;
        pc_n    = pc;
        inst_n  = inst_reg;
        pend_n  = npc_pend;
        buf_n   = npc_buf;
        unique case (state)
            S_IDLE: state_n = S_ADDR;
            S_ADDR: begin
                if (axi_arvalid && axi_arready)
                    state_n = S_DATA;
            end
            S_DATA: begin
                if (axi_rvalid && axi_rready) begin
                    inst_n  = axi_rdata;
                    state_n = S_HOLD;
                end
            end
            S_HOLD: begin
                if (id_ready)
                    state_n = S_WAIT_NPC;
            end
            S_WAIT_NPC: begin
                if (npc_valid) begin
                    pc_n    = npc;
                    pend_n  = 1'b0;
                    state_n = S_ADDR;
                end else if (npc_pend) begin
                    pc_n    = npc_buf;
                    pend_n  = 1'b0;
                    state_n = S_ADDR;
                end
            end
            default: state_n = S_IDLE;
        endcase
        if (npc_early) begin
            pend_n = 1'b1;
            buf_n  = npc;
        end
    end

    assign axi_arvalid = (state == S_ADDR);
    assign axi_rready  = (state == S_DATA);
    assign if_valid    = (state == S_HOLD);
    assign axi_araddr  = pc;
    assign if_pc       = pc;
    assign if_inst     = inst_reg;

    assign axi_awvalid = 1'b0;
    assign axi_wvalid  = 1'b0;
    assign axi_bready  = 1'b0;
    assign axi_wdata   = '0;

endmodule

// File: tb/tb_ysyx_24100006_ifu.sv
// Directed bench for ysyx_24100006_ifu with a small
// registered instruction-memory model on the AXI-Lite side.
module tb_ysyx_24100006_ifu;

    logic        clk;
    logic        reset;
    logic [31:0] axi_araddr;
    logic        axi_arvalid;
    logic        axi_arready;
    logic [31:0] axi_rdata;
    logic        axi_rvalid;
    logic        axi_rready;
    logic        axi_awvalid;
    logic        axi_wvalid;
    logic        axi_bready;
    logic [31:0] axi_wdata;
    logic [31:0] npc;
    logic        npc_valid;
    logic [31:0] if_inst;
    logic [31:0] if_pc;
    logic        if_valid;
    logic        id_ready;

    int n_checks = 0;
    int n_pass   = 0;

    ysyx_24100006_ifu dut (
        .clk         (clk),
        .reset       (reset),
        .axi_araddr  (axi_araddr),
        .axi_arvalid (axi_arvalid),
        .axi_arready (axi_arready),
        .axi_rdata   (axi_rdata),
        .axi_rvalid  (axi_rvalid),
        .axi_rready  (axi_rready),
        .axi_awvalid (axi_awvalid),
        .axi_wvalid  (axi_wvalid),
        .axi_bready  (axi_bready),
        .axi_wdata   (axi_wdata),
        .npc         (npc),
        .npc_valid   (npc_valid),
        .if_inst     (if_inst),
        .if_pc       (if_pc),
        .if_valid    (if_valid),
        .id_ready    (id_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] im_word(input logic [31:0] a);
        if (a == 32'h8000_0000) return 32'h0000_0413;
        return {a[15:0], 16'h0013};
    endfunction

    // IM: arready one cycle after arvalid, rvalid the cycle after.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            axi_arready <= 1'b0;
            axi_rvalid  <= 1'b0;
            axi_rdata   <= '0;
        end else begin
            axi_arready <= axi_arvalid && !axi_arready;
            if (axi_arvalid && axi_arready) begin
                axi_rvalid <= 1'b1;
                axi_rdata  <= im_word(axi_araddr);
            end else if (axi_rvalid && axi_rready) begin
                axi_rvalid <= 1'b0;
            end
        end
    end

    task automatic wait_hold(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (if_valid) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        reset = 1'b0; npc = '0; npc_valid = 1'b0; id_ready = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if (axi_araddr !== 32'h8000_0000 || if_pc !== 32'h8000_0000)
            $display("FAIL reset_pc: araddr=%h if_pc=%h want 80000000",
                     axi_araddr, if_pc);
        else n_pass++;
        n_checks++;
        if ({axi_arvalid, axi_rready, if_valid} !== 3'b000)
            $display("FAIL reset_hs: arv/rr/ifv=%b want 000",
                     {axi_arvalid, axi_rready, if_valid});
        else n_pass++;
        n_checks++;
        if (if_inst !== 32'h0 || axi_wdata !== 32'h0 ||
            {axi_awvalid, axi_wvalid, axi_bready} !== 3'b000)
            $display("FAIL reset_zero: inst=%h wdata=%h aw/w/b=%b want 0",
                     if_inst, axi_wdata,
                     {axi_awvalid, axi_wvalid, axi_bready});
        else n_pass++;
        reset = 1'b1;
    endtask

    task automatic test_first_fetch;
        @(negedge clk);
        n_checks++;
        if (axi_arvalid !== 1'b1 || axi_araddr !== 32'h8000_0000)
            $display("FAIL ff_c1_arvalid: arv=%b addr=%h want 1/80000000",
                     axi_arvalid, axi_araddr);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (axi_arvalid !== 1'b1 || if_valid !== 1'b0)
            $display("FAIL ff_c2_held: arv=%b ifv=%b want 1/0",
                     axi_arvalid, if_valid);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (axi_arvalid !== 1'b0 || axi_rready !== 1'b1 || if_valid !== 1'b0)
            $display("FAIL ff_c3_data: arv=%b rr=%b ifv=%b want 0/1/0",
                     axi_arvalid, axi_rready, if_valid);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (if_valid !== 1'b1 || if_inst !== 32'h0000_0413 ||
            if_pc !== 32'h8000_0000)
            $display("FAIL ff_c4_valid: ifv=%b inst=%h pc=%h want 1/00000413/80000000",
                     if_valid, if_inst, if_pc);
        else n_pass++;
    endtask

    task automatic test_hold_stall;
        id_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_checks++;
            if (if_valid !== 1'b1 || if_inst !== 32'h0000_0413 ||
                if_pc !== 32'h8000_0000 || axi_arvalid !== 1'b0)
                $display("FAIL stall_%0d: ifv=%b inst=%h pc=%h arv=%b",
                         i, if_valid, if_inst, if_pc, axi_arvalid);
            else n_pass++;
        end
        id_ready = 1'b1;
        @(negedge clk);
        id_ready = 1'b0;
        n_checks++;
        if (if_valid !== 1'b0 || axi_arvalid !== 1'b0)
            $display("FAIL stall_wait: ifv=%b arv=%b want 0/0",
                     if_valid, axi_arvalid);
        else n_pass++;
    endtask

    task automatic test_npc_wait;
        bit ok;
        repeat (2) begin
            @(negedge clk);
            n_checks++;
            if (axi_arvalid !== 1'b0)
                $display("FAIL wait_idle: arv=%b want 0", axi_arvalid);
            else n_pass++;
        end
        npc = 32'h8000_0004; npc_valid = 1'b1;
        @(negedge clk);
        npc_valid = 1'b0;
        n_checks++;
        if (axi_arvalid !== 1'b1 || axi_araddr !== 32'h8000_0004 ||
            if_pc !== 32'h8000_0004)
            $display("FAIL wait_fetch: arv=%b addr=%h pc=%h want 1/80000004",
                     axi_arvalid, axi_araddr, if_pc);
        else n_pass++;
        wait_hold(ok);
        n_checks++;
        if (!ok || if_inst !== 32'h0004_0013)
            $display("FAIL wait_inst: ok=%b inst=%h want 1/00040013",
                     ok, if_inst);
        else n_pass++;
    endtask

    task automatic test_npc_in_hold;
        bit ok;
        npc = 32'h8000_0010; npc_valid = 1'b1;
        @(negedge clk);
        npc_valid = 1'b0; id_ready = 1'b1;
        @(negedge clk);
        id_ready = 1'b0;
        n_checks++;
        if (axi_arvalid !== 1'b0 || if_valid !== 1'b0 ||
            if_pc !== 32'h8000_0004)
            $display("FAIL hold_pend_wait: arv=%b ifv=%b pc=%h want 0/0/80000004",
                     axi_arvalid, if_valid, if_pc);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (axi_arvalid !== 1'b1 || axi_araddr !== 32'h8000_0010)
            $display("FAIL hold_pend_fetch: arv=%b addr=%h want 1/80000010",
                     axi_arvalid, axi_araddr);
        else n_pass++;
        wait_hold(ok);
        n_checks++;
        if (!ok || if_inst !== 32'h0010_0013)
            $display("FAIL hold_pend_inst: ok=%b inst=%h want 1/00100013",
                     ok, if_inst);
        else n_pass++;
    endtask

    task automatic test_npc_overwrite;
        bit ok;
        npc = 32'h8000_0020; npc_valid = 1'b1;
        @(negedge clk);
        npc_valid = 1'b0;
        @(negedge clk);
        npc = 32'h8000_0040; npc_valid = 1'b1;
        @(negedge clk);
        npc_valid = 1'b0; id_ready = 1'b1;
        @(negedge clk);
        id_ready = 1'b0;
        @(negedge clk);
        n_checks++;
        if (axi_arvalid !== 1'b1 || axi_araddr !== 32'h8000_0040)
            $display("FAIL overwrite_fetch: arv=%b addr=%h want 1/80000040",
                     axi_arvalid, axi_araddr);
        else n_pass++;
        wait_hold(ok);
        n_checks++;
        if (!ok || if_pc !== 32'h8000_0040)
            $display("FAIL overwrite_pc: ok=%b pc=%h want 1/80000040",
                     ok, if_pc);
        else n_pass++;
    endtask

    task automatic test_npc_priority;
        bit ok;
        npc = 32'h8000_0050; npc_valid = 1'b1;
        @(negedge clk);
        npc_valid = 1'b0; id_ready = 1'b1;
        @(negedge clk);
        id_ready = 1'b0;
        npc = 32'h8000_0060; npc_valid = 1'b1;
        @(negedge clk);
        npc_valid = 1'b0;
        n_checks++;
        if (axi_arvalid !== 1'b1 || axi_araddr !== 32'h8000_0060)
            $display("FAIL prio_fetch: arv=%b addr=%h want 1/80000060",
                     axi_arvalid, axi_araddr);
        else n_pass++;
        wait_hold(ok);
        n_checks++;
        if (!ok || if_inst !== 32'h0060_0013)
            $display("FAIL prio_inst: ok=%b inst=%h want 1/00600013",
                     ok, if_inst);
        else n_pass++;
    endtask

    task automatic test_addr_ignored;
        bit ok;
        id_ready = 1'b1;
        @(negedge clk);
        id_ready = 1'b0;
        npc = 32'h8000_0070; npc_valid = 1'b1;
        @(negedge clk);
        npc = 32'h8000_0090;
        @(negedge clk);
        npc_valid = 1'b0;
        wait_hold(ok);
        n_checks++;
        if (!ok || if_pc !== 32'h8000_0070)
            $display("FAIL addr_ign_pc: ok=%b pc=%h want 1/80000070",
                     ok, if_pc);
        else n_pass++;
        id_ready = 1'b1;
        @(negedge clk);
        id_ready = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (axi_arvalid !== 1'b0 || if_pc !== 32'h8000_0070)
            $display("FAIL addr_ign_stay: arv=%b pc=%h want 0/80000070",
                     axi_arvalid, if_pc);
        else n_pass++;
        npc = 32'h8000_0100; npc_valid = 1'b1;
        @(negedge clk);
        npc_valid = 1'b0;
        wait_hold(ok);
        n_checks++;
        if (!ok || if_inst !== 32'h0100_0013)
            $display("FAIL addr_ign_next: ok=%b inst=%h want 1/01000013",
                     ok, if_inst);
        else n_pass++;
    endtask

    task automatic test_reset_mid_data;
        bit ok;
        bit seen;
        id_ready = 1'b1;
        @(negedge clk);
        id_ready = 1'b0;
        npc = 32'h8000_0200; npc_valid = 1'b1;
        @(negedge clk);
        npc_valid = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (axi_rready) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        n_checks++;
        if (!seen || if_pc !== 32'h8000_0200)
            $display("FAIL rst_reach_data: seen=%b pc=%h want 1/80000200",
                     seen, if_pc);
        else n_pass++;
        #2 reset = 1'b0;
        #1;
        n_checks++;
        if ({axi_arvalid, axi_rready, if_valid} !== 3'b000 ||
            if_pc !== 32'h8000_0000 || axi_araddr !== 32'h8000_0000)
            $display("FAIL rst_async: arv/rr/ifv=%b pc=%h want 000/80000000",
                     {axi_arvalid, axi_rready, if_valid}, if_pc);
        else n_pass++;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        n_checks++;
        if (axi_arvalid !== 1'b1 || axi_araddr !== 32'h8000_0000)
            $display("FAIL rst_restart: arv=%b addr=%h want 1/80000000",
                     axi_arvalid, axi_araddr);
        else n_pass++;
        wait_hold(ok);
        n_checks++;
        if (!ok || if_inst !== 32'h0000_0413 || if_pc !== 32'h8000_0000)
            $display("FAIL rst_refetch: ok=%b inst=%h pc=%h want 1/00000413/80000000",
                     ok, if_inst, if_pc);
        else n_pass++;
    endtask

    initial begin
        test_reset;
        test_first_fetch;
        test_hold_stall;
        test_npc_wait;
        test_npc_in_hold;
        test_npc_overwrite;
        test_npc_priority;
        test_addr_ignored;
        test_reset_mid_data;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
